// File: rtl/instruction_fetch_unit.sv
// Lucid64 fetch front end: owns the fetch PC, issues one outstanding imem request at a time,
// and hands instructions to decode through a one-entry hold buffer that absorbs stalled responses.
module instruction_fetch_unit #(
  parameter logic [63:0] RESET_ADDR = 64'h0000_0000_0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        FCH_squash_i,
  input  logic        FCH_stall_i,
  input  logic [63:0] redirect_target_i,
  output logic        imem_req_o,
  output logic [63:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        imem_stall_o,
  output logic        DCD_valid_o,
  output logic [31:0] DCD_inst_o,
  output logic [63:0] DCD_pc_o
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DISCARD} state_e;

  typedef struct packed {
    logic        vld;
    logic [31:0] inst;
    logic [63:0] pc;
  } hold_t;

  state_e      state_q;
  hold_t       hold_q;
  logic [63:0] pc_q, inflight_pc_q, redir_tgt_q;
  logic        redir_pend_q;

  logic        req, grant, rsp_live, deliver;
  logic [63:0] pc_inc_d;

  assign req      = (state_q == S_REQ) && !hold_q.vld && !rst_i;
  assign grant    = req && imem_gnt_i;
  assign rsp_live = (state_q == S_WAIT) && imem_rvalid_i;
  assign deliver  = hold_q.vld || rsp_live;
  assign pc_inc_d = pc_q + 64'd4;

  assign imem_req_o   = req;
  assign imem_addr_o  = pc_q;
  assign imem_stall_o = !deliver && !rst_i;
  assign DCD_valid_o  = deliver && !rst_i;
  assign DCD_inst_o   = hold_q.vld ? hold_q.inst : imem_rdata_i;
  assign DCD_pc_o     = hold_q.vld ? hold_q.pc   : inflight_pc_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q         <= RESET_ADDR;
      state_q      <= S_REQ;
      hold_q.vld   <= 1'b0;
      redir_pend_q <= 1'b0;
    end else if (FCH_squash_i) begin
      hold_q.vld <= 1'b0;
      case (state_q)
        S_REQ: begin
          if (req && !imem_gnt_i) begin
            // Request already on the bus must stay stable; park the target until it is granted.
            redir_pend_q <= 1'b1;
            redir_tgt_q  <= redirect_target_i;
          end else begin
            pc_q         <= redirect_target_i;
            redir_pend_q <= 1'b0;
            if (grant) begin
              inflight_pc_q <= pc_q;
              state_q       <= S_DISCARD;
            end
          end
        end
        S_WAIT, S_DISCARD: begin
          pc_q    <= redirect_target_i;
          state_q <= imem_rvalid_i ? S_REQ : S_DISCARD;
        end
        default: state_q <= S_REQ;
      endcase
    end else begin
      if (hold_q.vld && !FCH_stall_i) hold_q.vld <= 1'b0;
      case (state_q)
        S_REQ: begin
          if (grant) begin
            inflight_pc_q <= pc_q;
            if (redir_pend_q) begin
              pc_q         <= redir_tgt_q;
              redir_pend_q <= 1'b0;
              state_q      <= S_DISCARD;
            end else begin
              pc_q    <= pc_inc_d;
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (imem_rvalid_i) begin
            state_q <= S_REQ;
            if (FCH_stall_i) hold_q <= '{vld: 1'b1, inst: imem_rdata_i, pc: inflight_pc_q};
          end
        end
        S_DISCARD: if (imem_rvalid_i) state_q <= S_REQ;
        default: state_q <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench: expected request addresses and consumed instructions are queued with the
// stimulus and popped as the DUT grants/delivers. A second instance exercises PC wrap.
module tb_instruction_fetch_unit;

  logic        clk;
  logic        rst_i, FCH_squash_i, FCH_stall_i;
  logic [63:0] redirect_target_i;
  logic        imem_req_o, imem_gnt_i, imem_rvalid_i, imem_stall_o, DCD_valid_o;
  logic [63:0] imem_addr_o, DCD_pc_o;
  logic [31:0] imem_rdata_i, DCD_inst_o;

  logic        w_squash, w_stall, w_gnt, w_rvalid;
  logic [63:0] w_tgt, w_addr, w_pc;
  logic [31:0] w_rdata, w_inst;
  logic        w_req, w_stall_o, w_valid;

  instruction_fetch_unit u_dut (
    .clk_i(clk), .rst_i(rst_i), .FCH_squash_i(FCH_squash_i), .FCH_stall_i(FCH_stall_i),
    .redirect_target_i(redirect_target_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .imem_stall_o(imem_stall_o), .DCD_valid_o(DCD_valid_o), .DCD_inst_o(DCD_inst_o),
    .DCD_pc_o(DCD_pc_o)
  );

  instruction_fetch_unit #(.RESET_ADDR(64'hFFFF_FFFF_FFFF_FFFC)) u_wrap (
    .clk_i(clk), .rst_i(rst_i), .FCH_squash_i(w_squash), .FCH_stall_i(w_stall),
    .redirect_target_i(w_tgt), .imem_req_o(w_req), .imem_addr_o(w_addr),
    .imem_gnt_i(w_gnt), .imem_rvalid_i(w_rvalid), .imem_rdata_i(w_rdata),
    .imem_stall_o(w_stall_o), .DCD_valid_o(w_valid), .DCD_inst_o(w_inst),
    .DCD_pc_o(w_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  logic [63:0] aq[$], dq[$];
  logic        k_rst, k_stall, k_squash, k_gnt, k_rsp;
  logic [63:0] k_tgt;
  logic        pend, w_pend;
  logic [63:0] paddr, w_paddr;
  int          wn;
  logic [63:0] wexp [3] = '{64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'h4};

  function automatic logic [31:0] rd(logic [63:0] a);
    return {a[29:0], 2'b11};
  endfunction

  task automatic chk(string tag, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    logic [63:0] e;
    @(posedge clk); #1;
    rst_i = k_rst; FCH_stall_i = k_stall; FCH_squash_i = k_squash; redirect_target_i = k_tgt;
    imem_gnt_i = k_gnt;
    imem_rvalid_i = pend && k_rsp;
    imem_rdata_i  = pend ? rd(paddr) : 32'h0;
    w_rvalid = w_pend;
    w_rdata  = w_pend ? rd(w_paddr) : 32'h0;
    @(negedge clk);
    if (k_rst) begin
      chk("rst_req", imem_req_o, 0);
      chk("rst_vld", DCD_valid_o, 0);
      chk("rst_stall", imem_stall_o, 0);
      chk("w_rst_req", w_req, 0);
      pend = 0; w_pend = 0; wn = 0;
    end else begin
      if (imem_rvalid_i) pend = 0;
      if (imem_req_o && imem_gnt_i) begin
        chk("aq_len", aq.size() > 0, 1);
        e = (aq.size() > 0) ? aq.pop_front() : 64'hDEAD;
        chk("req_addr", imem_addr_o, e);
        pend = 1; paddr = imem_addr_o;
      end
      if (DCD_valid_o && !FCH_stall_i && !FCH_squash_i) begin
        chk("dq_len", dq.size() > 0, 1);
        e = (dq.size() > 0) ? dq.pop_front() : 64'hDEAD;
        chk("dcd_pc", DCD_pc_o, e);
        chk("dcd_inst", DCD_inst_o, rd(e));
      end
      chk("w_stall_o", w_stall_o, !w_rvalid);
      if (w_rvalid) begin
        chk("w_dcd_pc", w_pc, w_paddr);
        w_pend = 0;
      end
      if (w_req && w_gnt) begin
        if (wn < 3) chk("w_addr", w_addr, wexp[wn]);
        wn++;
        w_pend = 1; w_paddr = w_addr;
      end
    end
  endtask

  initial begin
    rst_i = 1; FCH_stall_i = 0; FCH_squash_i = 0; redirect_target_i = 0;
    imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = 0;
    w_squash = 0; w_stall = 0; w_gnt = 1; w_tgt = 0; w_rvalid = 0; w_rdata = 0;
    k_rst = 1; k_stall = 0; k_squash = 0; k_gnt = 1; k_rsp = 1; k_tgt = 0;
    pend = 0; w_pend = 0; paddr = 0; w_paddr = 0; wn = 0;
    tick(); tick();

    // reset release, 1-cycle memory
    k_rst = 0;
    aq.push_back(64'h0); aq.push_back(64'h4); aq.push_back(64'h8);
    dq.push_back(64'h0); dq.push_back(64'h4);
    tick(); chk("t1_stall_o", imem_stall_o, 1);
    tick(); chk("t2_req_off", imem_req_o, 0);
    tick();
    // response for 0x4 arrives under stall -> hold
    k_stall = 1; tick();
    chk("t4_vld", DCD_valid_o, 1); chk("t4_inst", DCD_inst_o, 32'h13);
    tick();
    chk("hold_req", imem_req_o, 0); chk("hold_vld", DCD_valid_o, 1);
    chk("hold_inst", DCD_inst_o, 32'h13); chk("hold_pc", DCD_pc_o, 64'h4);
    chk("hold_stall_o", imem_stall_o, 0);
    tick(); chk("hold_req2", imem_req_o, 0);
    k_stall = 0; tick(); chk("hold_rel_req", imem_req_o, 0);
    tick();                                  // grant 0x8

    // squash while waiting for 0x8
    aq.push_back(64'h1000);
    k_rsp = 0; k_squash = 1; k_tgt = 64'h1000; tick();
    chk("t9_vld", DCD_valid_o, 0);
    k_squash = 0; k_rsp = 1; tick();
    chk("disc_vld", DCD_valid_o, 0); chk("disc_stall_o", imem_stall_o, 1);
    dq.push_back(64'h1000); aq.push_back(64'h1004);
    tick(); tick();

    // squash against an ungranted request; newest target wins
    k_gnt = 0; k_squash = 1; k_tgt = 64'h2000; tick();
    chk("ug_req1", imem_req_o, 1); chk("ug_addr1", imem_addr_o, 64'h1004);
    k_tgt = 64'h3000; tick();
    chk("ug_addr2", imem_addr_o, 64'h1004);
    k_squash = 0; tick();
    chk("ug_req3", imem_req_o, 1); chk("ug_addr3", imem_addr_o, 64'h1004);
    aq.push_back(64'h3000); dq.push_back(64'h3000);
    k_gnt = 1; tick();                       // grant 0x1004, discarded
    tick(); chk("ug_disc_vld", DCD_valid_o, 0);
    tick(); tick();

    // squash coincident with rvalid in WAIT
    aq.push_back(64'h3004); aq.push_back(64'h4000);
    tick();
    k_squash = 1; k_tgt = 64'h4000; tick();
    chk("sq_rv_vld", DCD_valid_o, 1);
    k_squash = 0; tick();
    chk("sq_rv_req", imem_req_o, 1); chk("sq_rv_addr", imem_addr_o, 64'h4000);

    // squash clears a hold entry
    k_stall = 1; tick();
    chk("h2_vld", DCD_valid_o, 1); chk("h2_pc", DCD_pc_o, 64'h4000);
    k_squash = 1; k_tgt = 64'h5000; tick();
    chk("h2_sq_vld", DCD_valid_o, 1); chk("h2_sq_req", imem_req_o, 0);
    k_squash = 0; k_stall = 0;
    aq.push_back(64'h5000); dq.push_back(64'h5000);
    tick();
    chk("h2_clr_vld", DCD_valid_o, 0); chk("h2_clr_stall_o", imem_stall_o, 1);
    tick();
    k_gnt = 0; tick(); tick();

    chk("aq_left", aq.size(), 0);
    chk("dq_left", dq.size(), 0);
    chk("w_grants", wn >= 3, 1);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
